trng_entropy_collector: RTL
===========================

// Module: trng_entropy_collector
// PURPOSE
//  Consumer side of the trng32 word source: enables the ring-oscillator TRNG,
//  waits for warm-up, samples its 32-bit output at a fixed interval and runs
//  a repetition-count health test. Healthy samples go out as entropy events
//  over a valid/ready handshake, tagged with a round-robin Fortuna pool index.
//  Sits between trng32 and the Fortuna entropy-pool accumulator.
// PARAMETERS
//  WARMUP_CYCLES  64  cycles trng_en is high before the first sample (>=1)
//  SAMPLE_DIV     16  cycles in GAP between sampling points (>=1)
//  REP_LIMIT      4   identical consecutive samples that trip the test (>=2)
//  NUM_POOLS      32  pool index wraps at NUM_POOLS-1 (1..32)
// PORTS
//  clk          in   1   single clock
//  rst          in   1   synchronous, active-high reset
//  enable       in   1   request collection (level)
//  trng_en      out  1   drives trng32 en
//  trng_r       in   32  trng32 R
//  ev_valid     out  1   entropy event available
//  ev_ready     in   1   consumer accepts on valid&&ready at the rising edge
//  ev_data      out  32  event word, stable while ev_valid=1
//  ev_pool      out  5   target pool index, stable while ev_valid=1
//  health_fail  out  1   sticky repetition-test failure
// BEHAVIOUR
//  Reset: state=IDLE; trng_en=0, ev_valid=0, ev_data=0, ev_pool=0,
//   health_fail=0; counters, last_word and the rep-valid flag cleared.
//  States: IDLE, WARMUP, GAP, OUT, FAIL. trng_en=1 in WARMUP, GAP and OUT.
//  IDLE: enable=1 -> WARMUP, cnt=0.
//  WARMUP: cnt++; at cnt==WARMUP_CYCLES-1 -> GAP, cnt=0; enable=0 -> IDLE.
//  GAP: cnt++; enable=0 -> IDLE (aborts the pending sample).
//   At cnt==SAMPLE_DIV-1, capture trng_r:
//   - rep_cnt=1 if no previous sample or trng_r!=last_word; else rep_cnt+1.
//   - last_word=trng_r. If rep_cnt reaches REP_LIMIT -> FAIL (no event).
//   - Else ev_data=trng_r, ev_valid=1 -> OUT.
//  OUT: hold ev_data/ev_pool until handshake; enable is ignored.
//   On accept: ev_valid=0, ev_pool=(ev_pool==NUM_POOLS-1)?0:ev_pool+1,
//   then -> GAP (cnt=0) if enable=1, else -> IDLE.
//  FAIL: trng_en=0, ev_valid=0, health_fail=1; exits only on rst.
//  Latency: ev_valid rises WARMUP_CYCLES+SAMPLE_DIV edges after the edge
//   that samples enable=1. Min event spacing is SAMPLE_DIV+1 edges.
//  Leaving through IDLE keeps last_word, rep_cnt and ev_pool; a re-enable
//   repeats the full warm-up. rst mid-event drops the event, no accept.
//  Samples are never dropped. While OUT stalls, no sampling takes place.
// CONFIGURATION
//  TRNG_COLLECTOR_XORFOLD_EN defined: each event = XOR of two consecutive
//   health-checked samples. The first capture is stored and returns to GAP
//   (cnt=0). The second capture goes to OUT with ev_data=stored^trng_r.
//   The health test still runs on every raw capture. Rate is halved.
//  Undefined: one raw sample per event, as above.
// TESTING (bench: WARMUP_CYCLES=4, SAMPLE_DIV=2, REP_LIMIT=3, NUM_POOLS=4)
//  reset, enable=1, ready=1, trng_r=0x1234_5678 -> trng_en=1 one edge later;
//   ev_valid edge 6 after enable sample, ev_data=0x12345678, ev_pool=0.
//  ready=1, trng_r changes each sample -> ev_pool sequence 0,1,2,3,0;
//   events 3 edges apart.
//  trng_r held 0xDEAD_BEEF -> 2 events issued, 3rd capture -> health_fail=1,
//   trng_en=0, no 3rd event; enable toggling has no effect until rst.
//  ready=0 for 10 cycles in OUT -> ev_valid, ev_data and ev_pool held;
//   no new capture; accept when ready=1, next event 3 edges later.
//  enable dropped in WARMUP cycle 2 -> IDLE, trng_en=0 next edge;
//   re-enable needs the full 4 + 2 edges.
//  XORFOLD_EN, samples 0xFFFF_0000 then 0x0F0F_0F0F -> ev_data=0xF0F00F0F.

Source files
------------

// File: rtl/trng_entropy_collector.sv
// trng32 consumer: warm-up, periodic sampling, repetition-count health test,
// round-robin pool tagging. Optional XOR folding: TRNG_COLLECTOR_XORFOLD_EN.
module trng_entropy_collector #(
   parameter int unsigned WARMUP_CYCLES = 64,
   parameter int unsigned SAMPLE_DIV    = 16,
   parameter int unsigned REP_LIMIT     = 4,
   parameter int unsigned NUM_POOLS     = 32
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        enable,
   output logic        trng_en,
   input  logic [31:0] trng_r,
   output logic        ev_valid,
   input  logic        ev_ready,
   output logic [31:0] ev_data,
   output logic [4:0]  ev_pool,
   output logic        health_fail
);

   localparam logic [31:0] WARM_LAST = 32'(WARMUP_CYCLES - 1);
   localparam logic [31:0] DIV_LAST  = 32'(SAMPLE_DIV - 1);
   localparam logic [31:0] REP_LIM   = 32'(REP_LIMIT);
   localparam logic [4:0]  POOL_LAST = 5'(NUM_POOLS - 1);

   typedef enum logic [2:0] {
      IDLE, WARMUP, GAP, OUT, FAIL
   } state_t;

   state_t      state_q;
   logic [31:0] cnt_q;
   logic [31:0] rep_q;
   logic        rep_vld_q;
   logic [31:0] last_q;
   logic [31:0] data_q;
   logic [4:0]  pool_q;
   logic        valid_q;
   logic        en_q;
   logic        fail_q;
`ifdef TRNG_COLLECTOR_XORFOLD_EN
   logic [31:0] half_q;
   logic        half_vld_q;
`endif

   logic [31:0] rep_d;
   logic        rep_trip;

   always_comb begin
      rep_d = 32'd1;
      if (rep_vld_q && trng_r == last_q)
         rep_d = rep_q + 32'd1;
      rep_trip = (rep_d >= REP_LIM);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         rep_q     <= '0;
         rep_vld_q <= 1'b0;
         last_q    <= '0;
         data_q    <= '0;
         pool_q    <= '0;
         valid_q   <= 1'b0;
         en_q      <= 1'b0;
         fail_q    <= 1'b0;
`ifdef TRNG_COLLECTOR_XORFOLD_EN
         half_q     <= '0;
         half_vld_q <= 1'b0;
`endif
      end else begin
         unique case (state_q)
            IDLE: begin
               if (enable) begin
                  state_q <= WARMUP;
                  cnt_q   <= '0;
                  en_q    <= 1'b1;
               end
            end
            WARMUP: begin
               if (!enable) begin
                  state_q <= IDLE;
                  en_q    <= 1'b0;
               end else if (cnt_q == WARM_LAST) begin
                  state_q <= GAP;
                  cnt_q   <= '0;
               end else begin
                  cnt_q <= cnt_q + 32'd1;
               end
            end
            GAP: begin
               if (!enable) begin
                  state_q <= IDLE;
                  en_q    <= 1'b0;
               end else if (cnt_q == DIV_LAST) begin
                  rep_q     <= rep_d;
                  rep_vld_q <= 1'b1;
                  last_q    <= trng_r;
                  cnt_q     <= '0;
                  if (rep_trip) begin
                     state_q <= FAIL;
                     en_q    <= 1'b0;
                     fail_q  <= 1'b1;
                  end else begin
`ifdef TRNG_COLLECTOR_XORFOLD_EN
                     // first half of a fold is parked, second emits
                     if (!half_vld_q) begin
                        half_q     <= trng_r;
                        half_vld_q <= 1'b1;
                     end else begin
                        half_vld_q <= 1'b0;
                        data_q     <= half_q ^ trng_r;
                        valid_q    <= 1'b1;
                        state_q    <= OUT;
                     end
`else
                     data_q  <= trng_r;
                     valid_q <= 1'b1;
                     state_q <= OUT;
`endif
                  end
               end else begin
                  cnt_q <= cnt_q + 32'd1;
               end
            end
            OUT: begin
               if (ev_ready) begin
                  valid_q <= 1'b0;
                  pool_q  <= (pool_q == POOL_LAST) ? 5'd0 : pool_q + 5'd1;
                  cnt_q   <= '0;
                  if (enable) begin
                     state_q <= GAP;
                  end else begin
                     state_q <= IDLE;
                     en_q    <= 1'b0;
                  end
               end
            end
            default: begin
               en_q    <= 1'b0;
               valid_q <= 1'b0;
               fail_q  <= 1'b1;
            end
         endcase
      end
   end

   assign trng_en     = en_q;
   assign ev_valid    = valid_q;
   assign ev_data     = data_q;
   assign ev_pool     = pool_q;
   assign health_fail = fail_q;

endmodule
